// File: rtl/core85_pkg.sv
// Shared definitions for the 8085-style core: decoded-instruction bit map,
// T-state encoding, bus status codes and a machine-cycle field helper.
package core85_pkg;

  localparam int INST_GO6 = 0;
  localparam int INST_DAD = 1;
  localparam int INST_HLT = 2;
  localparam int INST_DIO = 3;
  localparam int INST_CYL = 4;
  localparam int INST_RWL = 8;
  localparam int INST_CCC = 12;

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    TW   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } tstate_e;

  localparam logic [1:0] ST_HALT  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_FETCH = 2'b11;

  localparam logic [2:0] MC_HALT = 3'd0;
  localparam logic [2:0] MC_M1   = 3'd1;
  localparam logic [2:0] MC_M2   = 3'd2;
  localparam logic [2:0] MC_M3   = 3'd3;

  // Per-cycle flag for M2..M5 out of a 4-bit field; M1 and out-of-range give 0.
  function automatic logic cyc_flag(input logic [3:0] field, input logic [2:0] mc);
    case (mc)
      3'd2:    cyc_flag = field[0];
      3'd3:    cyc_flag = field[1];
      3'd4:    cyc_flag = field[2];
      3'd5:    cyc_flag = field[3];
      default: cyc_flag = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cycctl.sv
// Machine-cycle / T-state controller: sequences M1..M5 bus cycles from the
// decoded instruction info and drives bus strobes, status and load enables.
module cycctl
  import core85_pkg::*;
#(
  parameter int INSTSIZE = 13,
  parameter int INFO_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTSIZE-1:0] chk_i,
  input  logic                ready,
  output logic                enb_c,
  output logic                enb_d,
  output logic                enbpc,
  output logic                enb_r,
  output logic                enb_w,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                iom,
  output logic                s1,
  output logic                s0,
  output logic [2:0]          mcyc
);

  tstate_e               state_r, state_s;
  logic [2:0]            mcyc_r, mcyc_s;
  logic                  run_r;
  logic                  go6_r, go6_s;
  logic                  hlt_r, hlt_s;
  logic                  dio_r, dio_s;
  logic [INFO_CYC-1:0]   cyl_r, cyl_s;
  logic [INFO_CYC-1:0]   rw_r, rw_s;
  logic                  pend_w_r, pend_w_s;

  logic                  ale_s, rd_s, wr_s, iom_s;
  logic [1:0]            st_s;
  logic                  enb_c_s, enb_d_s, enbpc_s, enb_r_s, enb_w_s;
  logic                  bus_s, wr_cyc_s;

  // DAD and CCC are decoded upstream for other blocks only.
  logic                  unused_s;
  assign unused_s = ^{chk_i[INST_DAD], chk_i[INSTSIZE-1:INST_CCC]};

  // Next T-state, machine cycle and instruction capture.
  always_comb begin
    state_s = state_r;
    mcyc_s  = mcyc_r;
    go6_s   = go6_r;
    hlt_s   = hlt_r;
    dio_s   = dio_r;
    cyl_s   = cyl_r;
    rw_s    = rw_r;
    if (!run_r) begin
      state_s = T1;
      mcyc_s  = MC_M1;
    end else begin
      case (state_r)
        T1: state_s = T2;
        T2, TW: begin
          if (ready) state_s = T3;
          else       state_s = TW;
        end
        T3: begin
          if (mcyc_r == MC_M1) begin
            state_s = T4;
            go6_s   = chk_i[INST_GO6];
            hlt_s   = chk_i[INST_HLT];
            dio_s   = chk_i[INST_DIO];
            cyl_s   = chk_i[INST_CYL +: INFO_CYC];
            rw_s    = chk_i[INST_RWL +: INFO_CYC];
          end else if (hlt_r && (mcyc_r == MC_M2)) begin
            state_s = HALT;
            mcyc_s  = MC_HALT;
          end else if (cyc_flag(cyl_r, mcyc_r + 3'd1)) begin
            state_s = T1;
            mcyc_s  = mcyc_r + 3'd1;
          end else begin
            state_s = T1;
            mcyc_s  = MC_M1;
          end
        end
        T4: begin
          if (go6_r) begin
            state_s = T5;
          end else begin
            state_s = T1;
            mcyc_s  = cyl_r[0] ? MC_M2 : MC_M1;
          end
        end
        T5: state_s = T6;
        T6: begin
          state_s = T1;
          mcyc_s  = cyl_r[0] ? MC_M2 : MC_M1;
        end
        HALT: begin
          state_s = HALT;
          mcyc_s  = MC_HALT;
        end
        default: begin
          state_s = T1;
          mcyc_s  = MC_M1;
        end
      endcase
    end
  end

  // Deferred register write-back: armed at the fetch, fired in the next M1 T1.
  always_comb begin
    if ((state_r == T3) && (mcyc_r == MC_M1)) begin
      pend_w_s = |chk_i[INST_CYL +: INFO_CYC];
    end else if ((state_s == T1) && (mcyc_s == MC_M1)) begin
      pend_w_s = 1'b0;
    end else begin
      pend_w_s = pend_w_r;
    end
  end

  // Output decode for the state being entered, so outputs can be registered.
  always_comb begin
    ale_s    = 1'b0;
    rd_s     = 1'b1;
    wr_s     = 1'b1;
    iom_s    = 1'b0;
    st_s     = ST_HALT;
    enb_c_s  = 1'b0;
    enb_d_s  = 1'b0;
    enbpc_s  = 1'b0;
    enb_r_s  = 1'b0;
    enb_w_s  = 1'b0;
    bus_s    = (state_s == T2) || (state_s == TW) || (state_s == T3);
    wr_cyc_s = cyc_flag(rw_s, mcyc_s);
    case (state_s)
      HALT: st_s = ST_HALT;
      default: begin
        ale_s = (state_s == T1);
        rd_s  = !(bus_s && !wr_cyc_s);
        wr_s  = !(bus_s && wr_cyc_s);
        iom_s = (mcyc_s == MC_M3) && dio_s;
        if (mcyc_s == MC_M1) begin
          st_s    = ST_FETCH;
          enbpc_s = (state_s == T2);
          enb_c_s = (state_s == T3);
          enb_w_s = ((state_s == T4) && (cyl_s == {INFO_CYC{1'b0}})) ||
                    ((state_s == T1) && pend_w_r);
        end else if (wr_cyc_s) begin
          st_s    = ST_WRITE;
          enb_r_s = bus_s;
        end else begin
          st_s    = ST_READ;
          enb_d_s = (state_s == T3);
        end
      end
    endcase
  end

  // State, captured instruction and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= T1;
      mcyc_r   <= MC_M1;
      run_r    <= 1'b0;
      go6_r    <= 1'b0;
      hlt_r    <= 1'b0;
      dio_r    <= 1'b0;
      cyl_r    <= {INFO_CYC{1'b0}};
      rw_r     <= {INFO_CYC{1'b0}};
      pend_w_r <= 1'b0;
      ale      <= 1'b0;
      rd_      <= 1'b1;
      wr_      <= 1'b1;
      iom      <= 1'b0;
      s1       <= 1'b0;
      s0       <= 1'b0;
      mcyc     <= MC_M1;
      enb_c    <= 1'b0;
      enb_d    <= 1'b0;
      enbpc    <= 1'b0;
      enb_r    <= 1'b0;
      enb_w    <= 1'b0;
    end else begin
      state_r  <= state_s;
      mcyc_r   <= mcyc_s;
      run_r    <= 1'b1;
      go6_r    <= go6_s;
      hlt_r    <= hlt_s;
      dio_r    <= dio_s;
      cyl_r    <= cyl_s;
      rw_r     <= rw_s;
      pend_w_r <= pend_w_s;
      ale      <= ale_s;
      rd_      <= rd_s;
      wr_      <= wr_s;
      iom      <= iom_s;
      s1       <= st_s[1];
      s0       <= st_s[0];
      mcyc     <= mcyc_s;
      enb_c    <= enb_c_s;
      enb_d    <= enb_d_s;
      enbpc    <= enbpc_s;
      enb_r    <= enb_r_s;
      enb_w    <= enb_w_s;
    end
  end

endmodule

// File: doc/cycctl.md
CYCCTL -- requirements
Module: cycctl

Interface
REQ-001 Parameter INSTSIZE, default 13: width of the decoded-instruction info vector chk_i.
REQ-002 Parameter INFO_CYC, default 4: width of the extra-cycle and read/write-per-cycle fields in chk_i.
REQ-003 clk  input  1  single clock; every state change occurs on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 chk_i  input  INSTSIZE  decoded instruction info: bit0 GO6, bit1 DAD, bit2 HLT, bit3 DIO, [7:4] extra cycles M2..M5, [11:8] write flag per M2..M5, bit12 CCC.
REQ-006 ready  input  1  memory/IO ready, sampled in T2 and TW.
REQ-007 enb_c, enb_d, enbpc, enb_r, enb_w  output  1 each  load enables to the register/ALU block: instruction, temp data, program counter, register read, register write.
REQ-008 ale  output  1  address latch enable.
REQ-009 rd_, wr_  output  1 each  active-low bus read and write strobes.
REQ-010 iom  output  1  1 = IO cycle, 0 = memory cycle.
REQ-011 s1, s0  output  1 each  bus status.
REQ-012 mcyc  output  3  current machine cycle: 1 to 5, or 0 when halted.

Function
REQ-013 T-state FSM shall have states T1, T2, TW, T3, T4, T5, T6, HALT; M1 (opcode fetch) shall run T1-T2-T3-T4, plus T5-T6 when GO6=1.
REQ-014 Every machine cycle: T1 asserts ale=1 for exactly one clock; T2, TW and T3 assert rd_=0 on read cycles and wr_=0 on write cycles; all other states hold rd_=wr_=1.
REQ-015 In T2, ready=0 shall enter TW; TW repeats while ready=0; ready=1 in T2 or TW proceeds to T3.
REQ-016 M1: enbpc pulses for one clock in T2; enb_c pulses in T3; s1,s0=11.
REQ-017 chk_i shall be sampled once, in T4 of M1, into an internal copy; later changes to chk_i shall not affect the current instruction.
REQ-018 After M1, cycle Mk (k=2..5) shall execute iff chk_i[INST_CYL+k-2]=1; the field is a thermometer code (0000, 0001, 0011, 0111, 1111).
REQ-019 Mk is a write cycle iff chk_i[INST_RWL+k-2]=1 (s1,s0=01, enb_r high through T2..T3); otherwise it is a read cycle (s1,s0=10, enb_d pulses in T3).
REQ-020 iom=1 only during M3 when DIO=1; iom=0 at all other times.
REQ-021 enb_w shall pulse once per instruction: in T4 of M1 when the extra-cycle field is 0000; otherwise in T1 of the following M1.
REQ-022 When HLT=1, the FSM shall enter HALT after M2 T3: ale=0, rd_=wr_=1, s1,s0=00, mcyc=0, all enables 0; it leaves HALT only on reset.
REQ-023 CCC and DAD are not consumed by this block.
REQ-024 After the last enabled cycle, the FSM returns to M1 T1.

Reset
REQ-025 While rst=1, outputs shall be: ale=0, rd_=1, wr_=1, iom=0, s1,s0=00, mcyc=1, all enables 0, and state T1 of M1.
REQ-026 Reset asserted mid-cycle shall force the reset values immediately, independent of clk.
REQ-027 The first ale pulse shall occur on the first rising edge after rst deasserts.

Structure
REQ-028 chk_i bit positions (INST_GO6..INST_CCC), the T-state encoding and the status codes shall live in shared package core85_pkg.
REQ-029 The block shall be one FSM plus a machine-cycle counter with no sub-module.

Verification
REQ-030 Drive 0x41 (MOV B,C; chk_i extra=0000): 4 clocks per instruction, enb_w in T4, next ale 4 clocks after the previous one.
REQ-031 Drive INX (GO6=1, extra=0000): 6-state M1; enbpc exactly once; next ale 6 clocks later.
REQ-032 Drive 0x36 (MVI M; extra=0011, rw=0010): M1 is 4 states, M2 is a read with enb_d in T3, M3 has wr_=0 for 2 clocks; total 10 clocks.
REQ-033 Hold ready=0 for 2 clocks during M2 T2: exactly 2 TW states; rd_ stays low for 4 clocks.
REQ-034 Drive 0x76 (HLT; extra=0001): HALT entered after M2, outputs idle, s1,s0=00 held for 20 clocks.
REQ-035 Assert rst during M2 T2: rd_=1 and ale=0 before the next edge; a fetch restarts with s1,s0=11.
